// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, status flags and datapath control strobes
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal
  );
  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM and decoders sequencing a multicycle RV32I datapath
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  state_t     state, next;
  logic       pcupdate, branch;
  logic [1:0] aluop;
  logic [2:0] fn_ctrl;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= state_t'(RESET_STATE);
    else state <= next;
  always_comb begin
    next          = state;
    pcupdate      = 1'b0;
    branch        = 1'b0;
    aluop         = ALU_ADD;
    bus.adrsrc    = 1'b0;
    bus.memwrite  = 1'b0;
    bus.irwrite   = 1'b0;
    bus.regwrite  = 1'b0;
    bus.resultsrc = 2'b00;
    bus.alusrca   = 2'b00;
    bus.alusrcb   = 2'b00;
    bus.illegal   = 1'b0;
    case (state)
      FETCH: begin
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
        bus.irwrite   = bus.mem_ready;
        pcupdate      = bus.mem_ready;
        next          = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
        next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
               (bus.op == OP_R)   ? EXECR  :
               (bus.op == OP_I)   ? EXECI  :
               (bus.op == OP_BR)  ? BRANCH :
               (bus.op == OP_JAL) ? JAL    : FETCH;
        bus.illegal = !(bus.op == OP_LW || bus.op == OP_SW || bus.op == OP_R ||
                        bus.op == OP_I || bus.op == OP_BR || bus.op == OP_JAL);
      end
      MEMADR: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        next = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.adrsrc = 1'b1;
        next = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.resultsrc = 2'b01;
        bus.regwrite  = 1'b1;
        next = FETCH;
      end
      MEMWRITE: begin
        bus.adrsrc   = 1'b1;
        bus.memwrite = 1'b1;
        next = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        bus.alusrca = 2'b10;
        aluop = ALU_FN;
        next = ALUWB;
      end
      EXECI: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        aluop = ALU_FN;
        next = ALUWB;
      end
      ALUWB: begin
        bus.regwrite = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        bus.alusrca = 2'b10;
        aluop  = ALU_SUB;
        branch = 1'b1;
        next = FETCH;
      end
      JAL: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        pcupdate = 1'b1;
        next = ALUWB;
      end
      default: next = FETCH;
    endcase
    // only R-type subtracts on funct3=000; I-type has op[5]=0 so addi stays add
    fn_ctrl = (bus.funct3 == 3'b000) ? ((bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000) :
              (bus.funct3 == 3'b010) ? 3'b101 :
              (bus.funct3 == 3'b110) ? 3'b011 :
              (bus.funct3 == 3'b111) ? 3'b010 : 3'b000;
    bus.alucontrol = (aluop == ALU_FN) ? fn_ctrl : (aluop == ALU_SUB) ? 3'b001 : 3'b000;
    bus.immsrc = (bus.op == OP_SW) ? 2'b01 : (bus.op == OP_BR) ? 2'b10 :
                 (bus.op == OP_JAL) ? 2'b11 : 2'b00;
    bus.pcwrite = pcupdate | (branch & (bus.zero ^ bus.funct3[0]));
    if (!reset) begin
      bus.pcwrite    = 1'b0;
      bus.adrsrc     = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regwrite   = 1'b0;
      bus.resultsrc  = 2'b00;
      bus.alusrca    = 2'b00;
      bus.alusrcb    = 2'b00;
      bus.immsrc     = 2'b00;
      bus.alucontrol = 3'b000;
      bus.illegal    = 1'b0;
    end
  end
endmodule
